// File: rtl/copperv_pkg.sv
// Shared types for the copperv memory path: request/response structs and
// the arbiter's state and owner encodings.
package copperv_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        en;
    logic        we;
  } mem_cmd_t;

  typedef struct packed {
    logic [31:0] rd_data;
    logic        ready;
  } mem_rsp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFETCH = 2'd1,
    OWN_DATA   = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/copperv_arb_watchdog.sv
// Wait-cycle counter for the memory arbiter; flags expiry once the count
// reaches TIMEOUT_CYCLES while enabled. TIMEOUT_CYCLES=0 disables expiry.
module copperv_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_count,
  output logic o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // Saturating so a disabled watchdog can never wrap back into range.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && i_count && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign o_expire = 1'b0;
    end else begin : g_on
      assign o_expire = i_enable && (r_cnt == CNT_W'(TIMEOUT_CYCLES));
    end
  endgenerate

endmodule

// File: rtl/copperv_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// state  | meaning
// IDLE   | no owner, arbitrating pending requests
// BUSY_I | fetch owns the port, waiting for memory ready
// BUSY_D | load/store owns the port, waiting for memory ready
module copperv_mem_arbiter
  import copperv_pkg::*;
#(
  parameter int ARB_MODE       = 1,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  mem_cmd_t   i_ifetch_cmd,
  output mem_rsp_t   o_ifetch_rsp,
  input  mem_cmd_t   i_data_cmd,
  output mem_rsp_t   o_data_rsp,
  output mem_cmd_t   o_mem_cmd,
  input  mem_rsp_t   i_mem_rsp,
  output logic [1:0] o_owner,
  output logic       o_timeout_err
);

  arb_state_t r_state;
  arb_state_t w_next;
  mem_cmd_t   r_mem_cmd;
  mem_cmd_t   w_sel_cmd;
  logic       r_rr_data;
  logic       w_busy;
  logic       w_conflict;
  logic       w_ready;
  logic       w_expire;
  logic       w_timeout;
  logic       w_done;
  logic       w_grant_i;
  logic       w_grant_d;

  assign w_busy     = (r_state != IDLE);
  assign w_conflict = i_ifetch_cmd.en && i_data_cmd.en;
  // A ready seen during reset is dropped; the transaction is being abandoned.
  assign w_ready    = w_busy && i_mem_rsp.ready && !i_rst;
  assign w_timeout  = w_expire && !i_mem_rsp.ready && !i_rst;
  assign w_done     = w_ready || w_timeout;

  copperv_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_done || !w_busy),
    .i_enable(w_busy),
    .i_count (!i_mem_rsp.ready),
    .o_expire(w_expire)
  );

  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (r_state == IDLE) begin
      if (w_conflict) begin
        if ((ARB_MODE == ARB_RR) && !r_rr_data) begin
          w_grant_i = 1'b1;
        end else begin
          w_grant_d = 1'b1;
        end
      end else begin
        w_grant_i = i_ifetch_cmd.en;
        w_grant_d = i_data_cmd.en;
      end
    end
  end

  always_comb begin
    w_sel_cmd    = w_grant_d ? i_data_cmd : i_ifetch_cmd;
    w_sel_cmd.en = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_next = BUSY_D;
        end else if (w_grant_i) begin
          w_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (w_done) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // r_rr_data set means the data requester wins the next conflict.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_cmd <= '0;
      r_rr_data <= 1'b0;
    end else begin
      if (w_grant_i || w_grant_d) begin
        r_mem_cmd <= w_sel_cmd;
      end else if (w_done) begin
        r_mem_cmd <= '0;
      end
      if ((ARB_MODE == ARB_RR) && (r_state == IDLE) && w_conflict) begin
        r_rr_data <= ~r_rr_data;
      end
    end
  end

  assign o_mem_cmd = r_mem_cmd;

  always_comb begin
    o_ifetch_rsp  = '0;
    o_data_rsp    = '0;
    o_owner       = OWN_NONE;
    o_timeout_err = w_timeout;
    case (r_state)
      BUSY_I: begin
        o_owner              = OWN_IFETCH;
        o_ifetch_rsp.ready   = w_done;
        o_ifetch_rsp.rd_data = w_ready ? i_mem_rsp.rd_data : 32'h0;
      end
      BUSY_D: begin
        o_owner            = OWN_DATA;
        o_data_rsp.ready   = w_done;
        o_data_rsp.rd_data = w_ready ? i_mem_rsp.rd_data : 32'h0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_copperv_mem_arbiter.sv
// Directed bench for copperv_mem_arbiter: a fixed-priority instance
// (watchdog 8) and a round-robin instance (watchdog 4) share all stimulus.
module tb_copperv_mem_arbiter;
  import copperv_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  mem_cmd_t ifc, dc;
  mem_rsp_t mrsp;

  mem_rsp_t   f_irsp, f_drsp, r_irsp, r_drsp;
  mem_cmd_t   f_mcmd, r_mcmd;
  logic [1:0] f_owner, r_owner;
  logic       f_terr, r_terr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  copperv_mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(8), .CNT_W(9)) dut_f (
    .i_clk(clk), .i_rst(rst),
    .i_ifetch_cmd(ifc), .o_ifetch_rsp(f_irsp),
    .i_data_cmd(dc), .o_data_rsp(f_drsp),
    .o_mem_cmd(f_mcmd), .i_mem_rsp(mrsp),
    .o_owner(f_owner), .o_timeout_err(f_terr)
  );

  copperv_mem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(4), .CNT_W(9)) dut_r (
    .i_clk(clk), .i_rst(rst),
    .i_ifetch_cmd(ifc), .o_ifetch_rsp(r_irsp),
    .i_data_cmd(dc), .o_data_rsp(r_drsp),
    .o_mem_cmd(r_mcmd), .i_mem_rsp(mrsp),
    .o_owner(r_owner), .o_timeout_err(r_terr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    ifc  = '0;
    dc   = '0;
    mrsp = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    ifc  = '0;
    dc   = '0;
    mrsp = '0;
    tick();
    tick();
    sample();
    n_checks++;
    if (f_owner !== 2'd0 || r_owner !== 2'd0) begin
      n_fail++; $display("FAIL reset_owner: got %0d/%0d want 0/0", f_owner, r_owner);
    end
    n_checks++;
    if (f_mcmd !== '0 || r_mcmd !== '0) begin
      n_fail++; $display("FAIL reset_mem_cmd: got %h/%h want 0", f_mcmd, r_mcmd);
    end
    n_checks++;
    if (f_terr !== 1'b0 || r_terr !== 1'b0 || f_irsp !== '0 || f_drsp !== '0) begin
      n_fail++; $display("FAIL reset_rsp: terr %b/%b irsp %h drsp %h want all 0", f_terr, r_terr, f_irsp, f_drsp);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch_only();
    int ipulse = 0;
    int dpulse = 0;
    do_reset();
    ifc.en = 1'b1; ifc.addr = 32'h100; ifc.we = 1'b0; ifc.wr_data = 32'h0;
    sample();
    n_checks++;
    if (f_mcmd.en !== 1'b0) begin
      n_fail++; $display("FAIL t1_en_cycle_n: got %b want 0", f_mcmd.en);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) begin
        mrsp.ready = 1'b1; mrsp.rd_data = 32'hDEADBEEF;
      end else begin
        mrsp = '0;
      end
      if (c == 5) ifc.en = 1'b0;
      sample();
      if (f_irsp.ready === 1'b1) ipulse++;
      if (f_drsp.ready === 1'b1) dpulse++;
      if (c == 1) begin
        n_checks++;
        if (f_mcmd.en !== 1'b1 || f_mcmd.addr !== 32'h100 || f_owner !== 2'd1) begin
          n_fail++; $display("FAIL t1_grant: en %b addr %h owner %0d want 1 100 1", f_mcmd.en, f_mcmd.addr, f_owner);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (f_irsp.ready !== 1'b1 || f_irsp.rd_data !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL t1_rsp: ready %b data %h want 1 deadbeef", f_irsp.ready, f_irsp.rd_data);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (f_owner !== 2'd0 || f_mcmd.en !== 1'b0) begin
          n_fail++; $display("FAIL t1_release: owner %0d en %b want 0 0", f_owner, f_mcmd.en);
        end
      end
    end
    n_checks++;
    if (ipulse != 1 || dpulse != 0) begin
      n_fail++; $display("FAIL t1_pulses: ifetch %0d data %0d want 1 0", ipulse, dpulse);
    end
  endtask

  task automatic test_fixed_priority();
    logic [1:0] exp_own [4];
    exp_own = '{2'd2, 2'd0, 2'd1, 2'd0};
    do_reset();
    mrsp.ready = 1'b1; mrsp.rd_data = 32'h0BADF00D;
    ifc.en = 1'b1; ifc.addr = 32'h104; ifc.we = 1'b0; ifc.wr_data = 32'h0;
    dc.en  = 1'b1; dc.addr  = 32'h2000; dc.we = 1'b1; dc.wr_data = 32'h12345678;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) dc.en = 1'b0;
      if (c == 4) ifc.en = 1'b0;
      sample();
      n_checks++;
      if (f_owner !== exp_own[c-1]) begin
        n_fail++; $display("FAIL t2_owner_c%0d: got %0d want %0d", c, f_owner, exp_own[c-1]);
      end
      if (c == 1) begin
        n_checks++;
        if (f_mcmd.addr !== 32'h2000 || f_mcmd.we !== 1'b1 || f_mcmd.wr_data !== 32'h12345678) begin
          n_fail++; $display("FAIL t2_data_cmd: addr %h we %b wd %h want 2000 1 12345678", f_mcmd.addr, f_mcmd.we, f_mcmd.wr_data);
        end
        n_checks++;
        if (f_drsp.ready !== 1'b1 || f_drsp.rd_data !== 32'h0BADF00D || f_irsp !== '0) begin
          n_fail++; $display("FAIL t2_data_rsp: drsp %h irsp %h want 0badf00d/1 and 0", f_drsp, f_irsp);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (f_drsp.ready !== 1'b0 || f_irsp.ready !== 1'b0) begin
          n_fail++; $display("FAIL t2_idle_ready: d %b i %b want 0 0", f_drsp.ready, f_irsp.ready);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (f_mcmd.addr !== 32'h104 || f_mcmd.we !== 1'b0 || f_irsp.ready !== 1'b1) begin
          n_fail++; $display("FAIL t2_fetch: addr %h we %b ready %b want 104 0 1", f_mcmd.addr, f_mcmd.we, f_irsp.ready);
        end
      end
    end
    mrsp = '0;
  endtask

  task automatic test_round_robin();
    int ipulse = 0;
    int dpulse = 0;
    logic [1:0] want;
    do_reset();
    mrsp.ready = 1'b1; mrsp.rd_data = 32'h00000077;
    ifc.en = 1'b1; ifc.addr = 32'h200;
    dc.en  = 1'b1; dc.addr  = 32'h3300;
    for (int c = 1; c <= 12; c++) begin
      tick();
      sample();
      if (r_irsp.ready === 1'b1) ipulse++;
      if (r_drsp.ready === 1'b1) dpulse++;
      want = (c % 2 == 0) ? 2'd0 : ((c % 4 == 1) ? 2'd1 : 2'd2);
      n_checks++;
      if (r_owner !== want) begin
        n_fail++; $display("FAIL t3_owner_c%0d: got %0d want %0d", c, r_owner, want);
      end
    end
    n_checks++;
    if (ipulse != 3 || dpulse != 3) begin
      n_fail++; $display("FAIL t3_pulses: ifetch %0d data %0d want 3 3", ipulse, dpulse);
    end
    ifc  = '0;
    dc   = '0;
    mrsp = '0;
  endtask

  task automatic test_timeout();
    int dpulse = 0;
    int tpulse = 0;
    do_reset();
    mrsp.ready = 1'b0; mrsp.rd_data = 32'hCAFEF00D;
    dc.en = 1'b1; dc.addr = 32'h3000; dc.we = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      sample();
      if (f_drsp.ready === 1'b1) dpulse++;
      if (f_terr === 1'b1) tpulse++;
      if (c == 1) begin
        n_checks++;
        if (f_mcmd.en !== 1'b1) begin
          n_fail++; $display("FAIL t4_en_rise: got %b want 1", f_mcmd.en);
        end
      end
      if (c == 9) begin
        n_checks++;
        if (f_drsp.ready !== 1'b1 || f_terr !== 1'b1 || f_drsp.rd_data !== 32'h0) begin
          n_fail++; $display("FAIL t4_expire: ready %b terr %b data %h want 1 1 0", f_drsp.ready, f_terr, f_drsp.rd_data);
        end
      end
    end
    n_checks++;
    if (dpulse != 1 || tpulse != 1) begin
      n_fail++; $display("FAIL t4_pulses: ready %0d terr %0d want 1 1", dpulse, tpulse);
    end
    tick();
    dc.en = 1'b0;
    ifc.en = 1'b1; ifc.addr = 32'h108;
    sample();
    n_checks++;
    if (f_owner !== 2'd0 || f_mcmd.en !== 1'b0 || f_terr !== 1'b0) begin
      n_fail++; $display("FAIL t4_release: owner %0d en %b terr %b want 0 0 0", f_owner, f_mcmd.en, f_terr);
    end
    tick();
    mrsp.ready = 1'b1; mrsp.rd_data = 32'h11112222;
    sample();
    n_checks++;
    if (f_owner !== 2'd1 || f_mcmd.addr !== 32'h108 || f_irsp.ready !== 1'b1 ||
        f_irsp.rd_data !== 32'h11112222 || f_terr !== 1'b0) begin
      n_fail++; $display("FAIL t4_next_fetch: owner %0d addr %h rsp %h terr %b want 1 108 11112222/1 0",
                         f_owner, f_mcmd.addr, f_irsp, f_terr);
    end
    tick();
    ifc  = '0;
    mrsp = '0;
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    dc.en = 1'b1; dc.addr = 32'h4000; dc.we = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    mrsp.ready = 1'b1; mrsp.rd_data = 32'h00000099;
    sample();
    n_checks++;
    if (f_drsp.ready !== 1'b0 || f_irsp.ready !== 1'b0) begin
      n_fail++; $display("FAIL t5_ready_in_rst: d %b i %b want 0 0", f_drsp.ready, f_irsp.ready);
    end
    tick();
    rst  = 1'b0;
    mrsp = '0;
    dc.en = 1'b0;
    ifc.en = 1'b1; ifc.addr = 32'h10C;
    sample();
    n_checks++;
    if (f_mcmd.en !== 1'b0 || f_owner !== 2'd0 || f_drsp.ready !== 1'b0 || f_irsp.ready !== 1'b0) begin
      n_fail++; $display("FAIL t5_abandon: en %b owner %0d d %b i %b want 0 0 0 0",
                         f_mcmd.en, f_owner, f_drsp.ready, f_irsp.ready);
    end
    tick();
    mrsp.ready = 1'b1; mrsp.rd_data = 32'h00000055;
    sample();
    n_checks++;
    if (f_owner !== 2'd1 || f_mcmd.addr !== 32'h10C || f_irsp.ready !== 1'b1 || f_irsp.rd_data !== 32'h55) begin
      n_fail++; $display("FAIL t5_after_reset: owner %0d addr %h rsp %h want 1 10c 55/1", f_owner, f_mcmd.addr, f_irsp);
    end
    tick();
    ifc  = '0;
    mrsp = '0;
  endtask

  task automatic test_ready_vs_expire();
    int early = 0;
    do_reset();
    dc.en = 1'b1; dc.addr = 32'h5000; dc.we = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      sample();
      if (r_terr === 1'b1 || r_drsp.ready === 1'b1) early++;
    end
    n_checks++;
    if (early != 0) begin
      n_fail++; $display("FAIL t6_early: got %0d early events want 0", early);
    end
    tick();
    mrsp.ready = 1'b1; mrsp.rd_data = 32'hA5A5A5A5;
    sample();
    n_checks++;
    if (r_drsp.ready !== 1'b1 || r_drsp.rd_data !== 32'hA5A5A5A5 || r_terr !== 1'b0) begin
      n_fail++; $display("FAIL t6_ready_wins: ready %b data %h terr %b want 1 a5a5a5a5 0",
                         r_drsp.ready, r_drsp.rd_data, r_terr);
    end
    tick();
    dc   = '0;
    mrsp = '0;
  endtask

  initial begin
    rst  = 1'b1;
    ifc  = '0;
    dc   = '0;
    mrsp = '0;
    test_reset();
    test_fetch_only();
    test_fixed_priority();
    test_round_robin();
    test_timeout();
    test_reset_mid_busy();
    test_ready_vs_expire();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
